// File: rtl/prio_interrupt_controller.sv
// prio_interrupt_controller
//
// Purpose:
//   Priority interrupt controller sitting between device interrupt lines,
//   the memory-bus config path and the core's interrupt handshake. Each
//   line can be edge or level triggered. Each line has a programmable
//   priority (0 = most urgent). A global threshold filters out lines whose
//   priority is not below it. One interrupt at a time is presented to the
//   core, together with its vector PC and line ID.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   irq_lines           raw device interrupt lines
//   cfg_we/sel/id/wdata config write port
//                       sel: 0 mask, 1 mode (1=level), 2 vector, 3 priority,
//                       4 threshold
//   cfg_rdata           combinational read of the register chosen by
//                       cfg_sel/cfg_id
//   pending             current pending vector
//   signal_interrupt    one-cycle request pulse to the core
//   int_accepted        core has taken the interrupt
//   interrupt_serviced  core finished the handler
//   interrupt_PC        vector of the active interrupt (0 when idle)
//   active_id           ID of the active interrupt
//   in_service          an interrupt is being signalled or serviced
//
// Optional feature macro: INT_ACCEPT_TIMEOUT_EN
//   When defined, WAIT_ACCEPT gives up after TIMEOUT_CYCLES cycles without
//   int_accepted. It returns to IDLE, keeps pending, and sets a sticky flag
//   that reads as cfg_rdata[31] with cfg_sel=4. Any threshold write clears
//   the flag.

module prio_interrupt_controller #(
  parameter int INTERRUPT_LINES = 32,
  parameter int INTERRUPT_BITS  = $clog2(INTERRUPT_LINES),
  parameter int PRIO_BITS       = 3,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INTERRUPT_LINES-1:0] irq_lines,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_sel,
  input  logic [INTERRUPT_BITS-1:0]  cfg_id,
  input  logic [31:0]                cfg_wdata,
  output logic [31:0]                cfg_rdata,
  output logic [INTERRUPT_LINES-1:0] pending,
  output logic                       signal_interrupt,
  input  logic                       int_accepted,
  input  logic                       interrupt_serviced,
  output logic [31:0]                interrupt_PC,
  output logic [INTERRUPT_BITS-1:0]  active_id,
  output logic                       in_service
);

  localparam int L = INTERRUPT_LINES;

  typedef enum logic [1:0] {IDLE, SIGNAL, WAIT_ACCEPT, IN_SERVICE} state_t;

  state_t                    state_q, state_d;
  logic [L-1:0]              mask_q, mask_d;
  logic [L-1:0]              mode_q, mode_d;
  logic [L-1:0]              pending_q, pending_d;
  logic [L-1:0]              irq_prev_q;
  logic [31:0]               vector_q [L];
  logic [31:0]               vector_d [L];
  logic [PRIO_BITS-1:0]      prio_q [L];
  logic [PRIO_BITS-1:0]      prio_d [L];
  logic [PRIO_BITS:0]        threshold_q, threshold_d;
  logic [INTERRUPT_BITS-1:0] active_id_q, active_id_d;

  logic                      id_valid;
  logic                      found;
  logic [INTERRUPT_BITS-1:0] best_id;
  logic [PRIO_BITS-1:0]      best_prio;
  logic                      service_done;
  logic                      timeout_expired;
  logic                      timeout_flag;

  // A non-power-of-two line count leaves some IDs without a backing line.
  assign id_valid = (int'(cfg_id) < L);

  // Config registers: a write lands at the next edge.
  always_comb begin
    mask_d      = mask_q;
    mode_d      = mode_q;
    vector_d    = vector_q;
    prio_d      = prio_q;
    threshold_d = threshold_q;
    if (cfg_we) begin
      case (cfg_sel)
        3'd0: mask_d = L'(cfg_wdata);
        3'd1: mode_d = L'(cfg_wdata);
        3'd2: if (id_valid) vector_d[cfg_id] = cfg_wdata;
        3'd3: if (id_valid) prio_d[cfg_id] = cfg_wdata[PRIO_BITS-1:0];
        3'd4: threshold_d = cfg_wdata[PRIO_BITS:0];
        default: ;
      endcase
    end
  end

  // Winner search: strict less-than keeps the lowest ID on a priority tie.
  always_comb begin
    found     = 1'b0;
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < L; i++) begin
      if (pending_q[i] && mask_q[i] && ({1'b0, prio_q[i]} < threshold_q) &&
          (!found || (prio_q[i] < best_prio))) begin
        found     = 1'b1;
        best_id   = INTERRUPT_BITS'(i);
        best_prio = prio_q[i];
      end
    end
  end

  // Handshake FSM and its outputs. Arbitration only happens in IDLE, so an
  // active interrupt is never preempted.
  always_comb begin
    state_d          = state_q;
    active_id_d      = active_id_q;
    service_done     = 1'b0;
    signal_interrupt = 1'b0;
    in_service       = 1'b0;
    interrupt_PC     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          active_id_d = best_id;
          state_d     = SIGNAL;
        end
      end
      SIGNAL: begin
        signal_interrupt = 1'b1;
        in_service       = 1'b1;
        interrupt_PC     = vector_q[active_id_q];
        state_d          = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        in_service   = 1'b1;
        interrupt_PC = vector_q[active_id_q];
        if (int_accepted) begin
          state_d = IN_SERVICE;
        end else if (timeout_expired) begin
          state_d = IDLE;
        end
      end
      IN_SERVICE: begin
        in_service   = 1'b1;
        interrupt_PC = vector_q[active_id_q];
        if (interrupt_serviced) begin
          service_done = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending update. For a line in edge mode, a fresh rising edge overrides
  // the service clear. Level lines just follow the masked input. Dropping the
  // mask or changing the mode wipes the bit in the same edge.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < L; i++) begin
      if (mode_q[i]) begin
        pending_d[i] = irq_lines[i] & mask_q[i];
      end else begin
        pending_d[i] = pending_q[i] &
                       ~(service_done && (active_id_q == INTERRUPT_BITS'(i)));
        if (irq_lines[i] && !irq_prev_q[i] && mask_q[i]) begin
          pending_d[i] = 1'b1;
        end
      end
      if (!mask_d[i] || (mode_d[i] != mode_q[i])) begin
        pending_d[i] = 1'b0;
      end
    end
  end

`ifdef INT_ACCEPT_TIMEOUT_EN
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_BITS-1:0] wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;

  // wait_cnt counts completed WAIT_ACCEPT cycles. It expires on the last one.
  // If a threshold write lands in the same edge as an expiry, the expiry wins.
  assign timeout_expired = (state_q == WAIT_ACCEPT) &&
                           (wait_cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1));
  assign timeout_flag    = timeout_q;

  always_comb begin
    wait_cnt_d = '0;
    if ((state_q == WAIT_ACCEPT) && (state_d == WAIT_ACCEPT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    timeout_d = timeout_q;
    if (cfg_we && (cfg_sel == 3'd4)) begin
      timeout_d = 1'b0;
    end
    if (timeout_expired && !int_accepted) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
`else
  assign timeout_expired = 1'b0;
  assign timeout_flag    = 1'b0;
`endif

  // State and configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      mode_q      <= '0;
      pending_q   <= '0;
      irq_prev_q  <= '0;
      threshold_q <= {1'b1, {PRIO_BITS{1'b0}}};
      active_id_q <= '0;
      for (int i = 0; i < L; i++) begin
        vector_q[i] <= '0;
        prio_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      irq_prev_q  <= irq_lines;
      threshold_q <= threshold_d;
      active_id_q <= active_id_d;
      vector_q    <= vector_d;
      prio_q      <= prio_d;
    end
  end

  // Config readback.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_sel)
      3'd0: cfg_rdata = 32'(mask_q);
      3'd1: cfg_rdata = 32'(mode_q);
      3'd2: if (id_valid) cfg_rdata = vector_q[cfg_id];
      3'd3: if (id_valid) cfg_rdata = 32'(prio_q[cfg_id]);
      3'd4: cfg_rdata = {timeout_flag, 31'(threshold_q)};
      default: cfg_rdata = '0;
    endcase
  end

  assign pending   = pending_q;
  assign active_id = active_id_q;

endmodule

// File: tb/tb_prio_interrupt_controller.sv
// tb_prio_interrupt_controller
//
// Purpose:
//   Self-checking bench for prio_interrupt_controller with 8 lines, 3-bit
//   priorities and an 8-cycle accept timeout. A behavioural model tracks the
//   controller from its rules. The model has pending bits, a busy/accepted
//   view of the handshake, and plain arrays for the config registers.
//   Every negedge compares all outputs against the model. The directed
//   sequences add literal expectations that pin the model itself.
//   The timeout sequence only runs when INT_ACCEPT_TIMEOUT_EN is defined.

module tb_prio_interrupt_controller;

  localparam int LINES = 8;
  localparam int IDB   = 3;
  localparam int TMO   = 8;
`ifdef INT_ACCEPT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [LINES-1:0] irq_lines = '0;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_sel = 3'd4;
  logic [IDB-1:0]   cfg_id = '0;
  logic [31:0]      cfg_wdata = '0;
  logic [31:0]      cfg_rdata;
  logic [LINES-1:0] pending;
  logic             signal_interrupt;
  logic             int_accepted = 1'b0;
  logic             interrupt_serviced = 1'b0;
  logic [31:0]      interrupt_PC;
  logic [IDB-1:0]   active_id;
  logic             in_service;

  int checks = 0;
  int errors = 0;

  prio_interrupt_controller #(
    .INTERRUPT_LINES(LINES),
    .INTERRUPT_BITS (IDB),
    .PRIO_BITS      (3),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .irq_lines         (irq_lines),
    .cfg_we            (cfg_we),
    .cfg_sel           (cfg_sel),
    .cfg_id            (cfg_id),
    .cfg_wdata         (cfg_wdata),
    .cfg_rdata         (cfg_rdata),
    .pending           (pending),
    .signal_interrupt  (signal_interrupt),
    .int_accepted      (int_accepted),
    .interrupt_serviced(interrupt_serviced),
    .interrupt_PC      (interrupt_PC),
    .active_id         (active_id),
    .in_service        (in_service)
  );

  always #5 clk = ~clk;

  // Model state.
  logic [LINES-1:0] m_mask, m_mode, m_pend, m_prev, m_newp, m_old_mask, m_old_mode;
  logic [31:0]      m_vec [LINES];
  int               m_prio [LINES];
  int               m_thr;
  bit               m_busy, m_sig, m_acc, m_tmo, m_clr;
  int               m_id, m_wcnt, m_best;

  // Compares one value and counts the result.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [2:0] sel, input logic [IDB-1:0] id);
    case (sel)
      3'd0: return {24'b0, m_mask};
      3'd1: return {24'b0, m_mode};
      3'd2: return m_vec[id];
      3'd3: return 32'(m_prio[id]);
      3'd4: return {m_tmo, 31'(m_thr)};
      default: return 32'h0;
    endcase
  endfunction

  // Model step on each clock edge, using the inputs that were stable before it.
  always @(posedge clk) begin
    if (rst) begin
      m_mask = '0; m_mode = '0; m_pend = '0; m_prev = '0;
      m_thr = 8; m_busy = 0; m_sig = 0; m_acc = 0; m_tmo = 0; m_id = 0; m_wcnt = 0;
      for (int i = 0; i < LINES; i++) begin
        m_vec[i] = '0;
        m_prio[i] = 0;
      end
    end else begin
      m_old_mask = m_mask;
      m_old_mode = m_mode;
      m_clr = 0;
      if (cfg_we && cfg_sel == 3'd4) m_tmo = 0;
      if (!m_busy) begin
        m_best = -1;
        for (int i = 0; i < LINES; i++)
          if (m_pend[i] && m_mask[i] && m_prio[i] < m_thr &&
              (m_best < 0 || m_prio[i] < m_prio[m_best])) m_best = i;
        if (m_best >= 0) begin
          m_busy = 1; m_sig = 1; m_acc = 0; m_id = m_best; m_wcnt = 0;
        end
      end else if (m_sig) begin
        m_sig = 0;
      end else if (!m_acc) begin
        if (int_accepted) m_acc = 1;
        else if (TMO_EN && m_wcnt + 1 == TMO) begin
          m_busy = 0; m_tmo = 1;
        end else m_wcnt++;
      end else if (interrupt_serviced) begin
        m_busy = 0; m_clr = 1;
      end
      for (int i = 0; i < LINES; i++) begin
        if (m_old_mode[i]) m_newp[i] = irq_lines[i] & m_old_mask[i];
        else begin
          m_newp[i] = m_pend[i];
          if (m_clr && m_id == i) m_newp[i] = 1'b0;
          if (irq_lines[i] && !m_prev[i] && m_old_mask[i]) m_newp[i] = 1'b1;
        end
      end
      if (cfg_we) begin
        case (cfg_sel)
          3'd0: m_mask = cfg_wdata[7:0];
          3'd1: m_mode = cfg_wdata[7:0];
          3'd2: m_vec[cfg_id] = cfg_wdata;
          3'd3: m_prio[cfg_id] = int'(cfg_wdata[2:0]);
          3'd4: m_thr = int'(cfg_wdata[3:0]);
          default: ;
        endcase
      end
      for (int i = 0; i < LINES; i++)
        if (!m_mask[i] || m_mode[i] != m_old_mode[i]) m_newp[i] = 1'b0;
      m_pend = m_newp;
      m_prev = irq_lines;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    checkOutput("cyc_signal", 32'(signal_interrupt), 32'(m_busy && m_sig));
    checkOutput("cyc_in_service", 32'(in_service), 32'(m_busy));
    checkOutput("cyc_pc", interrupt_PC, m_busy ? m_vec[m_id] : 32'h0);
    checkOutput("cyc_active_id", 32'(active_id), 32'(m_id));
    checkOutput("cyc_pending", 32'(pending), 32'(m_pend));
    checkOutput("cyc_rdata", cfg_rdata, model_rdata(cfg_sel, cfg_id));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the interrupt lines and lets the given number of edges pass.
  task automatic applyStimulus(input logic [LINES-1:0] irq, input int cycles);
    irq_lines = irq;
    repeat (cycles) tick();
  endtask

  task automatic cfgWrite(input logic [2:0] sel, input logic [IDB-1:0] id, input logic [31:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_id = id; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  // Waits (bounded) for the request pulse and checks which line won.
  task automatic waitSignal(input int exp_id, input string name);
    int n = 0;
    while (!signal_interrupt && n < 20) begin
      tick();
      n++;
    end
    if (!signal_interrupt) begin
      errors++;
      $display("[TB] FAIL %s: no signal_interrupt within 20 cycles, expected id %0d", name, exp_id);
    end
    checkOutput(name, 32'(active_id), 32'(exp_id));
  endtask

  // From SIGNAL: move into WAIT_ACCEPT, then accept.
  task automatic acceptIrq();
    tick();
    int_accepted = 1'b1;
    tick();
    int_accepted = 1'b0;
  endtask

  task automatic serviceIrq();
    interrupt_serviced = 1'b1;
    tick();
    interrupt_serviced = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset_in_service", 32'(in_service), 32'h0);
    checkOutput("reset_pending", 32'(pending), 32'h0);
    checkOutput("reset_threshold", cfg_rdata, 32'h8);

    $display("[TB] single edge interrupt on line 2");
    cfgWrite(3'd0, 0, 32'h5);
    cfgWrite(3'd2, 2, 32'h1000);
    applyStimulus(8'h04, 1);
    checkOutput("t1_pending_set", 32'(pending), 32'h04);
    applyStimulus(8'h00, 1);
    checkOutput("t1_signal_latency", 32'(signal_interrupt), 32'h1);
    checkOutput("t1_pc", interrupt_PC, 32'h1000);
    checkOutput("t1_id", 32'(active_id), 32'h2);
    acceptIrq();
    checkOutput("t1_in_service", 32'(in_service), 32'h1);
    serviceIrq();
    checkOutput("t1_pending_clear", 32'(pending), 32'h0);
    checkOutput("t1_in_service_off", 32'(in_service), 32'h0);

    $display("[TB] priority ordering and tie break");
    cfgWrite(3'd0, 0, 32'h82);
    cfgWrite(3'd3, 1, 32'd5);
    cfgWrite(3'd3, 7, 32'd2);
    applyStimulus(8'h82, 1);
    applyStimulus(8'h00, 0);
    waitSignal(7, "t2_first_line7");
    acceptIrq();
    serviceIrq();
    checkOutput("t2_idle_gap", 32'(in_service), 32'h0);
    tick();
    checkOutput("t2_b2b_signal", 32'(signal_interrupt), 32'h1);
    checkOutput("t2_second_line1", 32'(active_id), 32'h1);
    acceptIrq();
    serviceIrq();
    cfgWrite(3'd3, 1, 32'd3);
    cfgWrite(3'd3, 7, 32'd3);
    applyStimulus(8'h82, 1);
    applyStimulus(8'h00, 0);
    waitSignal(1, "t2_tie_line1");
    acceptIrq();
    serviceIrq();
    tick();
    checkOutput("t2_tie_then_line7", 32'(active_id), 32'h7);
    acceptIrq();
    serviceIrq();

    $display("[TB] threshold filtering");
    cfgWrite(3'd4, 0, 32'd3);
    cfgWrite(3'd0, 0, 32'h10);
    cfgWrite(3'd3, 4, 32'd3);
    applyStimulus(8'h10, 1);
    applyStimulus(8'h00, 4);
    checkOutput("t3_blocked", 32'(in_service), 32'h0);
    checkOutput("t3_still_pending", 32'(pending), 32'h10);
    cfgWrite(3'd4, 0, 32'd4);
    waitSignal(4, "t3_after_threshold");
    acceptIrq();
    serviceIrq();
    cfgWrite(3'd4, 0, 32'd8);

    $display("[TB] level mode on line 3");
    cfgWrite(3'd0, 0, 32'h08);
    cfgWrite(3'd1, 0, 32'h08);
    applyStimulus(8'h08, 1);
    waitSignal(3, "t4_level_first");
    acceptIrq();
    serviceIrq();
    checkOutput("t4_idle_gap", 32'(in_service), 32'h0);
    tick();
    checkOutput("t4_resignal", 32'(signal_interrupt), 32'h1);
    acceptIrq();
    irq_lines = 8'h00;
    serviceIrq();
    applyStimulus(8'h00, 3);
    checkOutput("t4_dropped_no_signal", 32'(in_service), 32'h0);
    checkOutput("t4_dropped_pending", 32'(pending), 32'h0);
    cfgWrite(3'd1, 0, 32'h0);

    $display("[TB] rise during service clear, then mask clear");
    cfgWrite(3'd0, 0, 32'h01);
    applyStimulus(8'h01, 1);
    applyStimulus(8'h00, 0);
    waitSignal(0, "t5_first");
    acceptIrq();
    irq_lines = 8'h01;
    serviceIrq();
    checkOutput("t5_set_wins", 32'(pending), 32'h01);
    applyStimulus(8'h00, 1);
    checkOutput("t5_resignal", 32'(signal_interrupt), 32'h1);
    acceptIrq();
    cfgWrite(3'd0, 0, 32'h0);
    checkOutput("t5_mask_clears", 32'(pending), 32'h0);
    checkOutput("t5_not_aborted", 32'(in_service), 32'h1);
    serviceIrq();

    $display("[TB] reset during service");
    cfgWrite(3'd2, 0, 32'h2000);
    cfgWrite(3'd0, 0, 32'h01);
    applyStimulus(8'h01, 1);
    applyStimulus(8'h00, 0);
    waitSignal(0, "t6_signal");
    acceptIrq();
    checkOutput("t6_pc_before", interrupt_PC, 32'h2000);
    rst = 1'b1;
    cfg_sel = 3'd2;
    cfg_id = 0;
    tick();
    checkOutput("t6_in_service", 32'(in_service), 32'h0);
    checkOutput("t6_pc", interrupt_PC, 32'h0);
    checkOutput("t6_id", 32'(active_id), 32'h0);
    checkOutput("t6_vector_reset", cfg_rdata, 32'h0);
    rst = 1'b0;
    tick();

`ifdef INT_ACCEPT_TIMEOUT_EN
    $display("[TB] accept timeout");
    cfgWrite(3'd0, 0, 32'h04);
    cfg_sel = 3'd4;
    applyStimulus(8'h04, 1);
    applyStimulus(8'h00, 0);
    waitSignal(2, "t7_signal");
    repeat (8) tick();
    checkOutput("t7_still_waiting", 32'(in_service), 32'h1);
    tick();
    checkOutput("t7_timed_out", 32'(in_service), 32'h0);
    checkOutput("t7_pending_kept", 32'(pending), 32'h04);
    checkOutput("t7_sticky", 32'(cfg_rdata[31]), 32'h1);
    tick();
    checkOutput("t7_resignal", 32'(signal_interrupt), 32'h1);
    acceptIrq();
    serviceIrq();
    cfgWrite(3'd4, 0, 32'd8);
    checkOutput("t7_sticky_cleared", cfg_rdata, 32'h8);
`endif

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
